// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative multiply/divide for the execute stage. Shift-add multiply or
//   restoring divide, one bit per clock, DATA_WIDTH iterations per operation.
//   The HI/LO registers downstream capture hi/lo on done.
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   : op[1]=1 selects two's-complement MULT/DIV
//     undefined : op[1] is ignored, MULT/DIV behave as MULTU/DIVU
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-low reset
//   start     in   request, sampled only while idle
//   op        in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   a, b      in   multiplicand/dividend, multiplier/divisor
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse, hi/lo valid from this cycle
//   hi        out  product upper half / remainder
//   lo        out  product lower half / quotient
//   div_zero  out  last completed division had b == 0
//
// Handshake: a request is taken at any rising edge where start=1 and busy=0
// (this includes the done cycle, which is already idle). While busy=1, start
// is ignored and a/b/op may change freely. done rises for exactly one cycle
// DATA_WIDTH+1 edges after acceptance; hi/lo/div_zero only change then or on
// reset.
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  // Multiply: {partial product, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   m_q;       // multiplicand or divisor magnitude
  logic [W-1:0]   a_raw_q;   // original a, returned as hi on divide by zero
  logic           is_div_q;
  logic           neg_lo_q;  // product / quotient must be negated at completion
  logic           neg_hi_q;  // remainder must be negated at completion
  logic           busy_q, done_q, div_zero_q;
  logic [W-1:0]   hi_q, lo_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning at latch time: magnitudes go into the datapath, the
  // signs are kept aside and applied once at completion.
  // ---------------------------------------------------------------------------
  logic         signed_op;
  logic [W-1:0] mag_a, mag_b;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = op[1];
`else
  assign signed_op = op[1] & 1'b0;
`endif

  assign mag_a = (signed_op && a[W-1]) ? -a : a;
  assign mag_b = (signed_op && b[W-1]) ? -b : b;

  // ---------------------------------------------------------------------------
  // One iteration of the datapath.
  // ---------------------------------------------------------------------------
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic         ge;

  always_comb begin
    sum     = '0;
    shifted = '0;
    ge      = 1'b0;
    acc_d   = acc_q;
    if (is_div_q) begin
      shifted = {acc_q[2*W-1:W], acc_q[W-1]};
      ge      = (shifted >= {1'b0, m_q});
      // When ge the difference is below the divisor, so W bits suffice.
      acc_d   = {(ge ? (shifted[W-1:0] - m_q) : shifted[W-1:0]),
                 acc_q[W-2:0], ge};
    end else begin
      sum   = {1'b0, acc_q[2*W-1:W]} + ({1'b0, m_q} & {(W+1){acc_q[0]}});
      acc_d = {sum, acc_q[W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Result formatting, used on the final iteration.
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] prod;
  logic [W-1:0]   hi_d, lo_d;
  logic           div_zero_d;

  always_comb begin
    prod       = neg_lo_q ? -acc_d : acc_d;
    hi_d       = prod[2*W-1:W];
    lo_d       = prod[W-1:0];
    div_zero_d = 1'b0;
    if (is_div_q) begin
      if (m_q == '0) begin
        hi_d       = a_raw_q;
        lo_d       = '1;
        div_zero_d = 1'b1;
      end else begin
        lo_d = neg_lo_q ? -acc_d[W-1:0]   : acc_d[W-1:0];
        hi_d = neg_hi_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(W);
            acc_q    <= {{W{1'b0}}, mag_a};
            m_q      <= mag_b;
            a_raw_q  <= a;
            is_div_q <= op[0];
            neg_lo_q <= signed_op & (a[W-1] ^ b[W-1]);
            neg_hi_q <= signed_op & a[W-1];
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
          end
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Bench for mul_div_unit (DATA_WIDTH = 32). A behavioural model computes
//   every result with plain 64-bit arithmetic and tracks the accept/complete
//   timeline; a compare process checks all outputs on every falling edge.
//   Directed cases with literal expectations pin the model and the DUT.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
  localparam int W = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference arithmetic: returns {div_zero, hi, lo}
  // ---------------------------------------------------------------------------
  function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    bit           sgn;
    longint       sx, sy, p, q, r;
    logic [W-1:0] rh, rl;
    logic         rdz;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`endif
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    rdz = 1'b0;
    if (!o[0]) begin
      p  = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == '0) begin
      rdz = 1'b1;
      rh  = x;
      rl  = '1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      rh = r[31:0];
      rl = q[31:0];
    end
    return {rdz, rh, rl};
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural timeline model: accept when idle, results appear W edges later
  // ---------------------------------------------------------------------------
  logic [2*W:0] m_pend = '0;
  int           m_left = 0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= W;
          m_busy <= 1'b1;
          m_pend <= ref_op(op, a, b);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_dz, m_hi, m_lo} <= m_pend;
        end
      end
    end
  end

  // Scoreboard compare, every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 65'(busy), 65'(m_busy));
      check("cyc_done", 65'(done), 65'(m_done));
      check("cyc_hi", 65'(hi), 65'(m_hi));
      check("cyc_lo", 65'(lo), 65'(m_lo));
      check("cyc_div_zero", 65'(div_zero), 65'(m_dz));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge)
  // ---------------------------------------------------------------------------
  // Caller is at the falling edge right after the accepting edge.
  task automatic wait_done(input bit noise, output int edges);
    edges = 1;
    while (!done && edges < 100) begin
      if (noise) start = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("done_seen", 65'(done), 65'(1));
  endtask

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit noise, output logic [W-1:0] rh, output logic [W-1:0] rl,
                       output logic rdz, output int edges);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    wait_done(noise, edges);
    rh  = hi;
    rl  = lo;
    rdz = div_zero;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rh, rl, x, y;
    logic [1:0]   o;
    logic         rdz;
    logic [2*W:0] r;
    int           edges;
    bit           saw;

    // Pin the reference arithmetic with hand-computed values
    r = ref_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("model_multu_max", 65'(r), {1'b0, 64'hFFFF_FFFE_0000_0001});
    r = ref_op(2'b01, 32'd100, 32'd7);
    check("model_divu", 65'(r), {1'b0, 32'd2, 32'd14});
    r = ref_op(2'b01, 32'h1234, 32'd0);
    check("model_div0", 65'(r), {1'b1, 32'h1234, 32'hFFFF_FFFF});

    // Reset
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_done", 65'(done), 65'(0));
    check("rst_hi", 65'(hi), 65'(0));
    check("rst_lo", 65'(lo), 65'(0));
    check("rst_div_zero", 65'(div_zero), 65'(0));
    reset = 1'b1;
    @(negedge clk);

    // MULTU max x max, latency and single-cycle done
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, rdz, edges);
    check("multu_hi", 65'(rh), 65'(32'hFFFF_FFFE));
    check("multu_lo", 65'(rl), 65'(32'h0000_0001));
    check("multu_latency", 65'(edges), 65'(33));
    @(negedge clk);
    check("done_one_cycle", 65'(done), 65'(0));

    // DIVU 100 / 7
    do_op(2'b01, 32'd100, 32'd7, 1'b0, rh, rl, rdz, edges);
    check("divu_lo", 65'(rl), 65'(14));
    check("divu_hi", 65'(rh), 65'(2));
    check("divu_dz", 65'(rdz), 65'(0));

    // DIVU by zero, then a multiply clears div_zero
    do_op(2'b01, 32'h1234, 32'd0, 1'b0, rh, rl, rdz, edges);
    check("div0_lo", 65'(rl), 65'(32'hFFFF_FFFF));
    check("div0_hi", 65'(rh), 65'(32'h1234));
    check("div0_dz", 65'(rdz), 65'(1));
    check("div0_latency", 65'(edges), 65'(33));
    do_op(2'b00, 32'd3, 32'd4, 1'b0, rh, rl, rdz, edges);
    check("mul34_lo", 65'(rl), 65'(12));
    check("mul34_hi", 65'(rh), 65'(0));
    check("mul34_dz", 65'(rdz), 65'(0));

    // start toggled throughout RUN is ignored
    do_op(2'b01, 32'd1000, 32'd3, 1'b1, rh, rl, rdz, edges);
    check("noise_lo", 65'(rl), 65'(333));
    check("noise_hi", 65'(rh), 65'(1));
    check("noise_latency", 65'(edges), 65'(33));

    // start held high through done: next op accepted on the done cycle
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd5;
    b     = 32'd6;
    @(negedge clk);
    edges = 1;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("held_done_seen", 65'(done), 65'(1));
    check("held_lo1", 65'(lo), 65'(30));
    @(negedge clk);
    check("held_busy_next", 65'(busy), 65'(1));
    start = 1'b0;
    wait_done(1'b0, edges);
    check("held_lo2", 65'(lo), 65'(30));
    check("held_latency2", 65'(edges), 65'(33));

    // Signed / unsigned interpretation of op[1]
`ifdef MULDIV_SIGNED_EN
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, rh, rl, rdz, edges);
    check("sdiv_lo", 65'(rl), 65'(32'hFFFF_FFFD));
    check("sdiv_hi", 65'(rh), 65'(32'hFFFF_FFFF));
    do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, rh, rl, rdz, edges);
    check("smul_hi", 65'(rh), 65'(32'hFFFF_FFFF));
    check("smul_lo", 65'(rl), 65'(32'hFFFF_FFF1));
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, rdz, edges);
    check("sdiv_ovf_lo", 65'(rl), 65'(32'h8000_0000));
    check("sdiv_ovf_hi", 65'(rh), 65'(0));
    do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, rh, rl, rdz, edges);
    check("sdiv0_lo", 65'(rl), 65'(32'hFFFF_FFFF));
    check("sdiv0_hi", 65'(rh), 65'(32'hFFFF_FFF9));
`else
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, rh, rl, rdz, edges);
    check("udiv_op11_lo", 65'(rl), 65'(32'h7FFF_FFFC));
    check("udiv_op11_hi", 65'(rh), 65'(1));
    do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, rh, rl, rdz, edges);
    check("umul_op10_hi", 65'(rh), 65'(32'h0000_0004));
    check("umul_op10_lo", 65'(rl), 65'(32'hFFFF_FFF1));
`endif

    // Reset mid-RUN with the iteration counter at 10: no done ever follows
    start = 1'b1;
    op    = 2'b01;
    a     = $urandom;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (W - 10) @(negedge clk);
    check("pre_reset_busy", 65'(busy), 65'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrun_rst_busy", 65'(busy), 65'(0));
    check("midrun_rst_hi", 65'(hi), 65'(0));
    check("midrun_rst_lo", 65'(lo), 65'(0));
    saw = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("midrun_rst_no_done", 65'(saw), 65'(0));

    // Randomised operations with idle gaps (including zero-gap back-to-back)
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 5))
        0: begin x = $urandom; y = '0; end
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom; y = 32'($urandom_range(1, 15)); end
        3: begin x = 32'($urandom_range(0, 20)); y = $urandom; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      r = ref_op(o, x, y);
      do_op(o, x, y, 1'($urandom), rh, rl, rdz, edges);
      check("rand_result", {rdz, rh, rl}, r);
      check("rand_latency", 65'(edges), 65'(W + 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit for the CPU execute stage. It accepts two operands and an opcode from the ID/EX pipeline, performs shift-add multiplication or restoring division one bit per cycle, and delivers a double-width result. The HI/LO pair of `simple_register` instances sits directly downstream. The pipeline stalls on `busy` and writes HI/LO on `done`.

## Interface
- `DATA_WIDTH`, default 32: operand width. Result is 2×`DATA_WIDTH`, split into `hi` and `lo`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, **synchronous, active-low**. 0 at a rising edge resets the block.
- `start`  in  1  request. Sampled only when idle.
- `op`  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `a`  in  `DATA_WIDTH`  multiplicand / dividend.
- `b`  in  `DATA_WIDTH`  multiplier / divisor.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  `DATA_WIDTH`  product upper half / remainder.
- `lo`  out  `DATA_WIDTH`  product lower half / quotient.
- `div_zero`  out  1  last completed division had `b`==0.

## Operation
- States: IDLE and RUN.
- Reset (`reset`==0 at an edge), from any state including mid-RUN:
  - state goes to IDLE;
  - `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0;
  - the iteration counter clears and any in-flight operation is discarded.
- IDLE → RUN: when `start`=1 at an edge. At that edge `a`, `b` and `op` are latched, the counter is set to `DATA_WIDTH`, and `busy` goes to 1.
- RUN: one iteration per edge; the counter decrements.
  - Multiply: add-and-shift on a 2×`DATA_WIDTH` accumulator.
  - Divide: restoring shift-subtract on a `DATA_WIDTH`+1-bit partial remainder.
- RUN → IDLE: at the edge where the counter reaches 0.
  - `hi`/`lo` are loaded.
  - `done`=1 for exactly one cycle.
  - `busy`=0.
- `start` while `busy`=1 is ignored. Latched operands are unaffected by changes on `a`/`b` during RUN.
- `start`=1 in the same cycle as `done`=1 is accepted, because the state is already IDLE.
- `hi`/`lo`/`div_zero` change only at completion or reset. They hold their value during RUN and in IDLE.
- Unsigned multiply: {`hi`,`lo`} = `a`×`b`, exact, with no truncation.
- Unsigned divide: `lo` = `a`/`b`, `hi` = `a` mod `b`.
- Divide by zero:
  - the operation still takes the full latency;
  - `lo` = all ones, `hi` = `a`, `div_zero`=1.
- `div_zero` is cleared to 0 by the completion of any non-zero-divisor operation, including a multiply.

## Timing
- Latency: with `start` accepted at edge N, `done` is high in the cycle after edge N+`DATA_WIDTH`.
  - That is 33 edges for `DATA_WIDTH`=32.
  - `busy` is high for exactly `DATA_WIDTH` cycles.
- Throughput: one operation per `DATA_WIDTH`+1 cycles with back-to-back `start`.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT/DIV are two's-complement.
  - Operand magnitudes are taken at latch time; the result sign is fixed at completion.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - -2^(W-1) / -1 gives `lo` = 0x80000000 and `hi` = 0 for W=32.
  - Signed divide by zero gives `lo` = all ones, `hi` = `a`.
- `MULDIV_SIGNED_EN` undefined: `op[1]` is ignored, and MULT/DIV behave exactly as MULTU/DIVU.
- Latency is identical in both builds.

## Test plan
- Reset: drive `reset`=0 mid-RUN (counter at 10).
  - Next cycle: `busy`=0, `hi`=`lo`=0, and no `done` ever follows.
- MULTU: `a`=0xFFFFFFFF, `b`=0xFFFFFFFF.
  - After 33 edges: `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses for 1 cycle.
- DIVU: `a`=100, `b`=7.
  - `lo`=14, `hi`=2, `div_zero`=0.
- DIVU by zero: `a`=0x1234, `b`=0.
  - `lo`=0xFFFFFFFF, `hi`=0x1234, `div_zero`=1.
  - A following MULTU 3×4 gives `lo`=12 and clears `div_zero`.
- Handshake:
  - `start` pulsed every cycle during RUN is ignored.
  - `start` held high through `done` starts the next op on the `done` cycle; `busy` is high the next cycle.
- Signed (macro on): DIV `a`=-7, `b`=2 gives `lo`=-3, `hi`=-1. MULT -3×5 gives {`hi`,`lo`} = -15 sign-extended.
  - Macro off: the same DIV stimulus gives the unsigned result, `lo`=0x7FFFFFFC and `hi`=1.
